// File: rtl/chip_top_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chip_top_pkg: shared constants and state encodings for chip_top       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package chip_top_pkg;

   localparam logic [7:0] c_addr_gpio_out = 8'h00;
   localparam logic [7:0] c_addr_gpio_oe  = 8'h01;
   localparam logic [7:0] c_addr_gpio_in  = 8'h02;
   localparam logic [7:0] c_addr_status   = 8'h03;

   localparam logic [7:0] c_cmd_write = 8'h57;
   localparam logic [7:0] c_cmd_read  = 8'h52;
   localparam logic [7:0] c_rsp_ack   = 8'h4B;

   typedef enum logic [1:0] {
      PS_IDLE = 2'd0,
      PS_ADDR = 2'd1,
      PS_DATA = 2'd2,
      PS_RESP = 2'd3
   } parse_state_e;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/chip_top_uart.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chip_top_uart: 8N1 receiver and transmitter with byte handshakes      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module chip_top_uart
   import chip_top_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1736
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       txd
);

   localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
   localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CLKS_PER_BIT - 1);
   localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

   logic               rxd_meta_q, rxd_sync_q, rxd_prev_q;
   rx_state_e          rx_state_q, rx_state_d;
   logic [c_cnt_w-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]         rx_bit_q, rx_bit_d;
   logic [7:0]         rx_shift_q, rx_shift_d;
   logic               rx_valid_q, rx_valid_d;
   logic               rx_ferr_q, rx_ferr_d;

   logic               tx_busy_q, tx_busy_d;
   logic [9:0]         tx_shift_q, tx_shift_d;
   logic [c_cnt_w-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]         tx_bit_q, tx_bit_d;
   logic               txd_q, txd_d;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid_d = 1'b0;
      rx_ferr_d  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rxd_prev_q && !rxd_sync_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            // Re-check the start bit at mid-bit to reject glitches
            if (rx_cnt_q == c_half) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == c_full) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == c_full) begin
               rx_cnt_d = '0;
               if (rxd_sync_q) begin
                  rx_valid_d = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_ferr_d  = 1'b1;
                  rx_state_d = RX_WAIT_HIGH;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_WAIT_HIGH: begin
            if (rxd_sync_q) begin
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_shift_d = tx_shift_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      txd_d      = txd_q;
      if (!tx_busy_q) begin
         if (tx_valid) begin
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, tx_data, 1'b0};
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            txd_d      = 1'b0;
         end
      end else if (tx_cnt_q == c_full) begin
         tx_cnt_d = '0;
         if (tx_bit_q == 4'd9) begin
            tx_busy_d = 1'b0;
            txd_d     = 1'b1;
         end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            txd_d      = tx_shift_q[1];
         end
      end else begin
         tx_cnt_d = tx_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
         tx_busy_q  <= 1'b0;
         tx_shift_q <= '1;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         txd_q      <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_valid_q <= rx_valid_d;
         rx_ferr_q  <= rx_ferr_d;
         tx_busy_q  <= tx_busy_d;
         tx_shift_q <= tx_shift_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         txd_q      <= txd_d;
      end
   end

   assign rx_data      = rx_shift_q;
   assign rx_valid     = rx_valid_q;
   assign rx_frame_err = rx_ferr_q;
   assign tx_ready     = !tx_busy_q;
   assign txd          = txd_q;

endmodule
`default_nettype wire

// File: rtl/chip_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chip_top: UART command port driving a 4-register map, GPIO, JTAG byp  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module chip_top
   import chip_top_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1736
) (
   input  logic clock,
   input  logic sys_rst_n,
   input  logic jtag_TCK,
   input  logic jtag_TMS,
   input  logic jtag_TDI,
   output logic jtag_TDO,
   input  logic custom_boot,
   inout  wire  gpio_0_0,
   inout  wire  gpio_0_1,
   inout  wire  gpio_0_2,
   inout  wire  gpio_0_3,
   inout  wire  gpio_0_4,
   inout  wire  gpio_0_5,
   inout  wire  gpio_0_6,
   inout  wire  gpio_0_7,
   output logic uart_0_txd,
   input  logic uart_0_rxd
);

   logic rst_meta_q, rst_sync_q, rst_n;

   always_ff @(posedge clock or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end
   assign rst_n = rst_sync_q;

   logic [7:0]   rx_data, resp_q, resp_d, rd_data, status, addr_q, addr_d;
   logic         rx_valid, rx_frame_err, tx_valid, tx_ready;
   parse_state_e ps_q, ps_d;
   logic         is_wr_q, is_wr_d;
   logic [7:0]   gpio_out_q, gpio_out_d, gpio_oe_q, gpio_oe_d;
   logic [7:0]   gpio_meta_q, gpio_in_q;
   logic         boot_q, boot_d, boot_done_q, boot_done_d;
   logic         ovr_q, ovr_d, ferr_q, ferr_d, ovr_set;
   logic [1:0]   status_clr;
   logic [7:0]   pad_in;

   chip_top_uart #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk         (clock),
      .rst_n       (rst_n),
      .rxd         (uart_0_rxd),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_frame_err(rx_frame_err),
      .tx_data     (resp_q),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .txd         (uart_0_txd)
   );

   assign pad_in = {gpio_0_7, gpio_0_6, gpio_0_5, gpio_0_4,
                    gpio_0_3, gpio_0_2, gpio_0_1, gpio_0_0};
   assign gpio_0_0 = gpio_oe_q[0] ? gpio_out_q[0] : 1'bz;
   assign gpio_0_1 = gpio_oe_q[1] ? gpio_out_q[1] : 1'bz;
   assign gpio_0_2 = gpio_oe_q[2] ? gpio_out_q[2] : 1'bz;
   assign gpio_0_3 = gpio_oe_q[3] ? gpio_out_q[3] : 1'bz;
   assign gpio_0_4 = gpio_oe_q[4] ? gpio_out_q[4] : 1'bz;
   assign gpio_0_5 = gpio_oe_q[5] ? gpio_out_q[5] : 1'bz;
   assign gpio_0_6 = gpio_oe_q[6] ? gpio_out_q[6] : 1'bz;
   assign gpio_0_7 = gpio_oe_q[7] ? gpio_out_q[7] : 1'bz;

   assign status = {5'b0, ferr_q, ovr_q, boot_q};

   always_comb begin
      case (rx_data)
         c_addr_gpio_out: rd_data = gpio_out_q;
         c_addr_gpio_oe:  rd_data = gpio_oe_q;
         c_addr_gpio_in:  rd_data = gpio_in_q;
         c_addr_status:   rd_data = status;
         default:         rd_data = 8'h00;
      endcase
   end

   always_comb begin
      ps_d       = ps_q;
      is_wr_d    = is_wr_q;
      addr_d     = addr_q;
      resp_d     = resp_q;
      gpio_out_d = gpio_out_q;
      gpio_oe_d  = gpio_oe_q;
      ovr_set    = 1'b0;
      status_clr = 2'b00;
      tx_valid   = 1'b0;
      case (ps_q)
         PS_IDLE: begin
            if (rx_valid && (rx_data == c_cmd_write || rx_data == c_cmd_read)) begin
               is_wr_d = (rx_data == c_cmd_write);
               ps_d    = PS_ADDR;
            end
         end
         PS_ADDR: begin
            if (rx_valid) begin
               addr_d = rx_data;
               if (is_wr_q) begin
                  ps_d = PS_DATA;
               end else begin
                  resp_d = rd_data;
                  ps_d   = PS_RESP;
               end
            end
         end
         PS_DATA: begin
            if (rx_valid) begin
               case (addr_q)
                  c_addr_gpio_out: gpio_out_d = rx_data;
                  c_addr_gpio_oe:  gpio_oe_d  = rx_data;
                  c_addr_status:   status_clr = rx_data[2:1];
                  default:         ;
               endcase
               resp_d = c_rsp_ack;
               ps_d   = PS_RESP;
            end
         end
         PS_RESP: begin
            tx_valid = 1'b1;
            ovr_set  = rx_valid;
            if (tx_ready) begin
               ps_d = PS_IDLE;
            end
         end
         default: ps_d = PS_IDLE;
      endcase
   end

   // Sticky flags: a set in the same cycle as a W1C clear takes priority
   assign ovr_d       = ovr_set | (ovr_q & ~status_clr[0]);
   assign ferr_d      = rx_frame_err | (ferr_q & ~status_clr[1]);
   assign boot_done_d = 1'b1;
   assign boot_d      = boot_done_q ? boot_q : custom_boot;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ps_q        <= PS_IDLE;
         is_wr_q     <= 1'b0;
         addr_q      <= '0;
         resp_q      <= '0;
         gpio_out_q  <= '0;
         gpio_oe_q   <= '0;
         gpio_meta_q <= '0;
         gpio_in_q   <= '0;
         ovr_q       <= 1'b0;
         ferr_q      <= 1'b0;
         boot_q      <= 1'b0;
         boot_done_q <= 1'b0;
      end else begin
         ps_q        <= ps_d;
         is_wr_q     <= is_wr_d;
         addr_q      <= addr_d;
         resp_q      <= resp_d;
         gpio_out_q  <= gpio_out_d;
         gpio_oe_q   <= gpio_oe_d;
         gpio_meta_q <= pad_in;
         gpio_in_q   <= gpio_meta_q;
         ovr_q       <= ovr_d;
         ferr_q      <= ferr_d;
         boot_q      <= boot_d;
         boot_done_q <= boot_done_d;
      end
   end

   logic       tck_meta_q, tck_sync_q, tck_prev_q;
   logic       tms_meta_q, tms_sync_q, tdi_meta_q, tdi_sync_q;
   logic       bypass_q, bypass_d, tdo_q, tdo_d;
   logic [2:0] tms_cnt_q, tms_cnt_d;
   logic       tck_rise, tck_fall;

   assign tck_rise = tck_sync_q & ~tck_prev_q;
   assign tck_fall = ~tck_sync_q & tck_prev_q;

   always_comb begin
      bypass_d  = bypass_q;
      tdo_d     = tdo_q;
      tms_cnt_d = tms_cnt_q;
      if (tck_rise) begin
         bypass_d = tdi_sync_q;
         if (!tms_sync_q) begin
            tms_cnt_d = 3'd0;
         end else if (tms_cnt_q >= 3'd4) begin
            // Fifth consecutive TMS-high edge: logic reset of the bypass path
            tms_cnt_d = 3'd5;
            bypass_d  = 1'b0;
            tdo_d     = 1'b0;
         end else begin
            tms_cnt_d = tms_cnt_q + 1'b1;
         end
      end
      if (tck_fall) begin
         tdo_d = bypass_q;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         tck_meta_q <= 1'b0;
         tck_sync_q <= 1'b0;
         tck_prev_q <= 1'b0;
         tms_meta_q <= 1'b0;
         tms_sync_q <= 1'b0;
         tdi_meta_q <= 1'b0;
         tdi_sync_q <= 1'b0;
         bypass_q   <= 1'b0;
         tdo_q      <= 1'b0;
         tms_cnt_q  <= 3'd0;
      end else begin
         tck_meta_q <= jtag_TCK;
         tck_sync_q <= tck_meta_q;
         tck_prev_q <= tck_sync_q;
         tms_meta_q <= jtag_TMS;
         tms_sync_q <= tms_meta_q;
         tdi_meta_q <= jtag_TDI;
         tdi_sync_q <= tdi_meta_q;
         bypass_q   <= bypass_d;
         tdo_q      <= tdo_d;
         tms_cnt_q  <= tms_cnt_d;
      end
   end

   assign jtag_TDO = tdo_q;

endmodule
`default_nettype wire

// File: tb/tb_chip_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_chip_top: directed UART/GPIO/JTAG vectors for chip_top             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_chip_top;

   localparam int CPB = 16;

   logic clock = 1'b0;
   logic sys_rst_n = 1'b0;
   logic tck = 1'b0, tms = 1'b0, tdi = 1'b0;
   logic custom_boot = 1'b1;
   logic rxd = 1'b1;
   wire  txd, tdo;
   wire  gp0, gp1, gp2, gp3, gp4, gp5, gp6, gp7;
   logic [3:0] drv_en = 4'h0;
   logic [3:0] drv_val = 4'h0;
   wire  [7:0] pads;

   int total = 0;
   int bad = 0;
   logic [7:0] rxq[$];

   always #5 clock = ~clock;

   pullup pu_0 (gp0);
   pullup pu_1 (gp1);
   pullup pu_2 (gp2);
   pullup pu_3 (gp3);
   pullup pu_4 (gp4);
   pullup pu_5 (gp5);
   pullup pu_6 (gp6);
   pullup pu_7 (gp7);
   assign gp4 = drv_en[0] ? drv_val[0] : 1'bz;
   assign gp5 = drv_en[1] ? drv_val[1] : 1'bz;
   assign gp6 = drv_en[2] ? drv_val[2] : 1'bz;
   assign gp7 = drv_en[3] ? drv_val[3] : 1'bz;
   assign pads = {gp7, gp6, gp5, gp4, gp3, gp2, gp1, gp0};

   chip_top #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clock      (clock),
      .sys_rst_n  (sys_rst_n),
      .jtag_TCK   (tck),
      .jtag_TMS   (tms),
      .jtag_TDI   (tdi),
      .jtag_TDO   (tdo),
      .custom_boot(custom_boot),
      .gpio_0_0   (gp0),
      .gpio_0_1   (gp1),
      .gpio_0_2   (gp2),
      .gpio_0_3   (gp3),
      .gpio_0_4   (gp4),
      .gpio_0_5   (gp5),
      .gpio_0_6   (gp6),
      .gpio_0_7   (gp7),
      .uart_0_txd (txd),
      .uart_0_rxd (rxd)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Host-side UART receiver collecting every reply frame
   initial begin : rx_model
      logic [7:0] b;
      forever begin
         @(negedge clock);
         if (txd === 1'b0) begin
            repeat (CPB / 2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clock);
               b[i] = txd;
            end
            repeat (CPB) @(negedge clock);
            if (txd === 1'b1) rxq.push_back(b);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      rxd = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clock);
      end
      rxd = 1'b1;
      repeat (CPB) @(negedge clock);
   endtask

   task automatic expect_reply(input string tag, input logic [7:0] exp);
      int n;
      n = 0;
      while (rxq.size() == 0 && n < 14 * CPB) begin
         @(negedge clock);
         n++;
      end
      if (rxq.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got no reply (timeout) expected %h", tag, exp);
      end else begin
         check(tag, rxq.pop_front(), exp);
      end
   endtask

   task automatic cmd_write(input string tag, input logic [7:0] a, input logic [7:0] d);
      send_byte(8'h57);
      send_byte(a);
      send_byte(d);
      expect_reply(tag, 8'h4B);
   endtask

   task automatic cmd_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
      send_byte(8'h52);
      send_byte(a);
      expect_reply(tag, exp);
   endtask

   task automatic jtag_cycle(input logic tdi_v, input logic tms_v);
      @(negedge clock);
      tdi = tdi_v;
      tms = tms_v;
      tck = 1'b1;
      repeat (6) @(negedge clock);
      tck = 1'b0;
      repeat (6) @(negedge clock);
   endtask

   initial begin : main
      int n;
      repeat (4) @(negedge clock);
      sys_rst_n = 1'b1;
      repeat (6) @(negedge clock);

      check("rst_txd", {7'b0, txd}, 8'h01);
      check("rst_tdo", {7'b0, tdo}, 8'h00);
      check("rst_pads", pads, 8'hFF);
      cmd_read("rd_status_boot", 8'h03, 8'h01);

      cmd_write("wr_oe_ack", 8'h01, 8'hFF);
      cmd_write("wr_out_ack", 8'h00, 8'hA5);
      check("pads_a5", pads, 8'hA5);
      cmd_read("rd_in_a5", 8'h02, 8'hA5);
      cmd_read("rd_oe_ff", 8'h01, 8'hFF);

      cmd_write("wr_oe_0f", 8'h01, 8'h0F);
      check("pads_f5", pads, 8'hF5);
      drv_val = 4'h0;
      drv_en  = 4'hF;
      repeat (4) @(negedge clock);
      check("pads_05", pads, 8'h05);
      cmd_read("rd_in_05", 8'h02, 8'h05);
      cmd_read("rd_out_a5", 8'h00, 8'hA5);
      drv_en = 4'h0;

      rxd = 1'b0;
      repeat (30 * CPB) @(negedge clock);
      rxd = 1'b1;
      repeat (2 * CPB) @(negedge clock);
      cmd_read("rd_status_ferr", 8'h03, 8'h05);
      cmd_write("wr_status_w1c", 8'h03, 8'h04);
      cmd_read("rd_status_clr", 8'h03, 8'h01);

      cmd_read("rd_unmapped", 8'h7F, 8'h00);
      cmd_write("wr_unmapped", 8'h7F, 8'h12);
      cmd_read("rd_out_kept", 8'h00, 8'hA5);
      cmd_read("rd_oe_kept", 8'h01, 8'h0F);
      send_byte(8'h00);
      repeat (12 * CPB) @(negedge clock);
      check("junk_no_reply", 8'(rxq.size()), 8'h00);
      cmd_read("rd_after_junk", 8'h00, 8'hA5);

      jtag_cycle(1'b1, 1'b0);
      check("jtag_b0", {7'b0, tdo}, 8'h01);
      jtag_cycle(1'b0, 1'b0);
      check("jtag_b1", {7'b0, tdo}, 8'h00);
      jtag_cycle(1'b1, 1'b0);
      check("jtag_b2", {7'b0, tdo}, 8'h01);
      jtag_cycle(1'b1, 1'b0);
      check("jtag_b3", {7'b0, tdo}, 8'h01);
      for (int i = 0; i < 4; i++) jtag_cycle(1'b1, 1'b1);
      check("jtag_tms4", {7'b0, tdo}, 8'h01);
      @(negedge clock);
      tck = 1'b1;
      repeat (6) @(negedge clock);
      check("jtag_tms5_rise", {7'b0, tdo}, 8'h00);
      tck = 1'b0;
      repeat (6) @(negedge clock);
      check("jtag_tms5_fall", {7'b0, tdo}, 8'h00);
      tms = 1'b0;

      // Reset in the middle of a reply frame
      send_byte(8'h52);
      send_byte(8'h03);
      n = 0;
      while (txd !== 1'b0 && n < 4 * CPB) begin
         @(negedge clock);
         n++;
      end
      check("reply_started", {7'b0, txd}, 8'h00);
      repeat (3 * CPB) @(negedge clock);
      custom_boot = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      check("midframe_txd", {7'b0, txd}, 8'h01);
      check("midframe_tdo", {7'b0, tdo}, 8'h00);
      repeat (3) @(negedge clock);
      sys_rst_n = 1'b1;
      repeat (12 * CPB) @(negedge clock);
      rxq.delete();
      check("rst2_pads", pads, 8'hFF);
      cmd_read("rd_status_boot0", 8'h03, 8'h00);
      cmd_read("rd_out_rst", 8'h00, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
